// File: rtl/display_reader.sv
// Frame-buffer read-out engine: walks the buffer with a one-cycle-latency
// active-low read strobe and streams each word out as a pixel with row/frame markers.
module display_reader #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 392,
  parameter int ROW_LEN = 28
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] RDATA,
  output logic              READn,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              row_end,
  output logic              frame_end,
  output logic              busy,
  output logic              clc
);

  localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(ROW_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [COL_W-1:0] col;
  logic             last_addr;
  logic             last_col;

  assign last_addr = (ADDR == LAST_ADDR);
  assign last_col  = (col == LAST_COL);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FETCH;
      S_FETCH: next_state = S_WAIT;
      S_WAIT:  next_state = S_SEND;
      S_SEND:  if (pix_ready) next_state = last_addr ? S_DONE : S_FETCH;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Address and column only advance on an accepted pixel, so a stalled
  // pixel keeps its data and markers until the handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ADDR     <= '0;
      col      <= '0;
      pix_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ADDR <= '0;
            col  <= '0;
          end
        end
        S_WAIT: pix_data <= RDATA;
        S_SEND: begin
          if (pix_ready && !last_addr) begin
            ADDR <= ADDR + ADDR_W'(1);
            col  <= last_col ? '0 : col + COL_W'(1);
          end
        end
        S_DONE: begin
          ADDR <= '0;
          col  <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    READn     = 1'b1;
    pix_valid = 1'b0;
    row_end   = 1'b0;
    frame_end = 1'b0;
    busy      = 1'b1;
    clc       = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_FETCH: READn = 1'b0;
      S_SEND: begin
        pix_valid = 1'b1;
        row_end   = last_col;
        frame_end = last_addr;
      end
      S_DONE:  clc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader: the stimulus pushes each frame's expected
// pixel list, and a negedge monitor checks every presented pixel, strobe and clc pulse.
module tb_display_reader;

  localparam int ADDR_W      = 11;
  localparam int DEPTH       = 392;
  localparam int ROW_LEN     = 28;
  localparam int S_ADDR_W    = 3;
  localparam int S_DEPTH     = 8;
  localparam int S_ROW_LEN   = 4;
  localparam int FRAME_LIMIT = 3 * DEPTH * 8 + 100;

  typedef struct {
    logic [7:0] data;
    int         addr;
    logic       row_end;
    logic       frame_end;
  } exp_pix_t;

  logic              CLK       = 1'b0;
  logic              RESET     = 1'b1;
  logic              start     = 1'b0;
  logic              pix_ready = 1'b1;
  logic [7:0]        RDATA     = 8'h00;
  logic              READn;
  logic [ADDR_W-1:0] ADDR;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              row_end;
  logic              frame_end;
  logic              busy;
  logic              clc;

  logic                s_start = 1'b0;
  logic                s_ready = 1'b1;
  logic [7:0]          s_rdata = 8'h00;
  logic                s_readn;
  logic [S_ADDR_W-1:0] s_addr;
  logic [7:0]          s_data;
  logic                s_valid;
  logic                s_row_end;
  logic                s_frame_end;
  logic                s_busy;
  logic                s_clc;

  int         checks        = 0;
  int         failures      = 0;
  int         cycle         = 0;
  int         ready_mode    = 0;
  logic [7:0] mem_key       = 8'h5A;
  exp_pix_t   q[$];
  bit         clc_due       = 1'b0;
  bit         strobed       = 1'b0;
  int         clc_count     = 0;
  int         row_end_count = 0;
  int         s_n           = 0;
  int         s_clc_count   = 0;
  int         s_row_count   = 0;

  display_reader #(.ADDR_W(ADDR_W), .DATA_W(8), .DEPTH(DEPTH), .ROW_LEN(ROW_LEN)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .RDATA(RDATA), .READn(READn), .ADDR(ADDR),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .row_end(row_end),
    .frame_end(frame_end), .busy(busy), .clc(clc)
  );

  display_reader #(.ADDR_W(S_ADDR_W), .DATA_W(8), .DEPTH(S_DEPTH), .ROW_LEN(S_ROW_LEN)) small_dut (
    .CLK(CLK), .RESET(RESET), .start(s_start), .RDATA(s_rdata), .READn(s_readn), .ADDR(s_addr),
    .pix_data(s_data), .pix_valid(s_valid), .pix_ready(s_ready), .row_end(s_row_end),
    .frame_end(s_frame_end), .busy(s_busy), .clc(s_clc)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle++;

  // Memories answer one cycle after a strobe and return noise otherwise.
  always @(posedge CLK) begin
    RDATA   <= !READn ? (ADDR[7:0] ^ mem_key) : 8'($urandom);
    s_rdata <= !s_readn ? (8'(s_addr) ^ 8'hC3) : 8'($urandom);
  end

  always @(posedge CLK) begin
    #2;
    pix_ready = (ready_mode == 0) ? 1'b1 :
                (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    s_ready   = ($urandom_range(0, 1) != 0);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] key);
    exp_pix_t e;
    mem_key = key;
    for (int n = 0; n < DEPTH; n++) begin
      e.data      = 8'(n) ^ key;
      e.addr      = n;
      e.row_end   = ((n % ROW_LEN) == ROW_LEN - 1);
      e.frame_end = (n == DEPTH - 1);
      q.push_back(e);
    end
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // kind 0: pixel at addr presented, 1: strobe at addr, 2: clc pulse
  task automatic waitSignal(input int kind, input int addr, input string name);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < FRAME_LIMIT) begin
      case (kind)
        0:       hit = pix_valid && (int'(ADDR) == addr);
        1:       hit = !READn && (int'(ADDR) == addr);
        default: hit = clc;
      endcase
      if (!hit) begin
        @(posedge CLK); #1;
        n++;
      end
    end
    checkOutput(name, int'(hit), 1);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < FRAME_LIMIT) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput(name, int'(busy), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_readn"}, int'(READn), 1);
    checkOutput({tag, "_addr"}, int'(ADDR), 0);
    checkOutput({tag, "_pix_data"}, int'(pix_data), 0);
    checkOutput({tag, "_pix_valid"}, int'(pix_valid), 0);
    checkOutput({tag, "_row_end"}, int'(row_end), 0);
    checkOutput({tag, "_frame_end"}, int'(frame_end), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_clc"}, int'(clc), 0);
  endtask

  always @(negedge CLK) begin
    checkOutput("clc", int'(clc), int'(clc_due));
    clc_due = 1'b0;
    if (clc) clc_count++;
    if (!READn) begin
      if (q.size() == 0) begin
        checkOutput("strobe_without_pixel", 1, 0);
      end else begin
        checkOutput("strobe_addr", int'(ADDR), q[0].addr);
        checkOutput("strobe_once", int'(strobed), 0);
        strobed = 1'b1;
      end
    end
    if (pix_valid) begin
      if (q.size() == 0) begin
        checkOutput("unexpected_pixel", 1, 0);
      end else begin
        checkOutput("pix_data", int'(pix_data), int'(q[0].data));
        checkOutput("pix_addr", int'(ADDR), q[0].addr);
        checkOutput("row_end", int'(row_end), int'(q[0].row_end));
        checkOutput("frame_end", int'(frame_end), int'(q[0].frame_end));
        checkOutput("fetched_before_send", int'(strobed), 1);
        if (pix_ready && !RESET) begin
          if (row_end) row_end_count++;
          clc_due = q[0].frame_end;
          strobed = 1'b0;
          void'(q.pop_front());
        end
      end
    end
    if (RESET) begin
      q.delete();
      clc_due = 1'b0;
      strobed = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (s_clc) s_clc_count++;
    if (s_valid && s_ready && !RESET) begin
      checkOutput("small_data", int'(s_data), int'(8'(s_n) ^ 8'hC3));
      checkOutput("small_row_end", int'(s_row_end), int'((s_n % S_ROW_LEN) == S_ROW_LEN - 1));
      checkOutput("small_frame_end", int'(s_frame_end), int'(s_n == S_DEPTH - 1));
      if (s_row_end) s_row_count++;
      s_n++;
    end
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cycle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fetch_cycle;
    int clc0;
    int rows0;

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    checkResetValues("reset");

    $display("[TB] full frame, start latency, no backpressure");
    while (cycle < 10) begin
      @(posedge CLK); #1;
    end
    clc0  = clc_count;
    rows0 = row_end_count;
    applyStimulus(8'h5A);
    fetch_cycle = cycle;
    checkOutput("latency_readn", int'(READn), 0);
    checkOutput("latency_addr", int'(ADDR), 0);
    checkOutput("latency_busy", int'(busy), 1);
    @(posedge CLK); #1;
    checkOutput("latency_wait_valid", int'(pix_valid), 0);
    @(posedge CLK); #1;
    checkOutput("latency_send_valid", int'(pix_valid), 1);
    waitIdle("frame_a_idle");
    checkOutput("frame_a_cycles", cycle - fetch_cycle, 3 * DEPTH + 1);
    checkOutput("frame_a_clc_pulses", clc_count - clc0, 1);
    checkOutput("frame_a_row_ends", row_end_count - rows0, DEPTH / ROW_LEN);
    checkOutput("frame_a_drained", q.size(), 0);

    $display("[TB] start while busy, random backpressure");
    ready_mode = 1;
    clc0 = clc_count;
    applyStimulus(8'($urandom));
    waitSignal(0, 10, "busy_wait_pix10");
    pulseStart();
    waitSignal(0, 200, "busy_wait_pix200");
    pulseStart();
    waitSignal(2, 0, "busy_wait_clc");
    pulseStart();
    checkOutput("done_start_ignored", int'(busy), 0);
    repeat (10) begin
      @(posedge CLK); #1;
    end
    checkOutput("busy_still_idle", int'(busy), 0);
    checkOutput("busy_clc_pulses", clc_count - clc0, 1);
    checkOutput("busy_drained", q.size(), 0);

    $display("[TB] backpressure on pixel 3");
    ready_mode = 0;
    clc0 = clc_count;
    applyStimulus(8'h5A);
    waitSignal(1, 3, "bp_fetch3");
    ready_mode = 2;
    waitSignal(0, 3, "bp_pix3");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", int'(pix_valid), 1);
      checkOutput("bp_addr", int'(ADDR), 3);
      checkOutput("bp_row_end", int'(row_end), 0);
      checkOutput("bp_readn", int'(READn), 1);
      @(posedge CLK); #1;
    end
    ready_mode = 0;
    waitSignal(0, 4, "bp_pix4");
    waitIdle("bp_idle");
    checkOutput("bp_clc_pulses", clc_count - clc0, 1);
    checkOutput("bp_drained", q.size(), 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'($urandom));
    waitSignal(0, 100, "mid_wait_pix100");
    clc0 = clc_count;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    checkResetValues("mid_reset");
    repeat (5) begin
      @(posedge CLK); #1;
    end
    checkOutput("mid_reset_no_clc", clc_count - clc0, 0);
    checkOutput("mid_reset_idle", int'(busy), 0);

    ready_mode = 1;
    clc0 = clc_count;
    applyStimulus(8'($urandom));
    waitIdle("after_reset_idle");
    checkOutput("after_reset_clc_pulses", clc_count - clc0, 1);
    checkOutput("after_reset_drained", q.size(), 0);

    $display("[TB] short rows on the small instance");
    s_start = 1'b1;
    @(posedge CLK); #1;
    s_start = 1'b0;
    for (int n = 0; n < FRAME_LIMIT && s_busy; n++) begin
      @(posedge CLK); #1;
    end
    checkOutput("small_idle", int'(s_busy), 0);
    checkOutput("small_pixels", s_n, S_DEPTH);
    checkOutput("small_row_ends", s_row_count, S_DEPTH / S_ROW_LEN);
    checkOutput("small_clc_pulses", s_clc_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
